timer_counter: RTL and testbench

- 64-bit timer count and compare stage, directly downstream of the divider/count-control stage.
- Advances one step each cycle that count_en from the count-control stage is high.
- Compares the count against a software-programmed 64-bit value and raises a sticky, maskable interrupt.
- Supports debug halt via a request/acknowledge handshake, plus software load of counter and compare registers in 32-bit halves.

---
 rtl/timer_counter.sv | 136 +++++++++++++
 tb/tb_timer_counter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_counter.sv
// timer_counter
//   64-bit timer count and compare stage fed by the count-control stage.
//   The counter advances once per cycle while count_en is high, the timer is
//   enabled and no debug halt is requested or active. A software-programmed
//   compare value raises a sticky interrupt status bit, which int_en masks.
//   Debug halt uses a level request/acknowledge handshake.
//
// Ports
//   clk        system clock, all state updates on the rising edge
//   rst        asynchronous active-high reset
//   timer_en   timer enable; its falling edge zeroes the counter
//   count_en   per-cycle advance strobe
//   halt_req   debug halt request (level)
//   halt_ack   debug halt acknowledge (level)
//   wdata      software write data for the lo/hi register halves
//   cnt_wr_lo  write wdata into counter bits [31:0]
//   cnt_wr_hi  write wdata into counter bits [63:32]
//   cmp_wr_lo  write wdata into compare bits [31:0]
//   cmp_wr_hi  write wdata into compare bits [63:32]
//   int_en     interrupt enable (mask only, never clears int_st)
//   int_clr    write-1-to-clear pulse for int_st
//   cnt_val    current counter value
//   cmp_val    current compare value
//   int_st     sticky interrupt status
//   intr       interrupt line, int_st & int_en
module timer_counter #(
    parameter int              DATA_W  = 32,
    parameter int              CNT_W   = 2 * DATA_W,
    parameter logic [CNT_W-1:0] CMP_RST = '1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              timer_en,
    input  logic              count_en,
    input  logic              halt_req,
    output logic              halt_ack,
    input  logic [DATA_W-1:0] wdata,
    input  logic              cnt_wr_lo,
    input  logic              cnt_wr_hi,
    input  logic              cmp_wr_lo,
    input  logic              cmp_wr_hi,
    input  logic              int_en,
    input  logic              int_clr,
    output logic [CNT_W-1:0]  cnt_val,
    output logic [CNT_W-1:0]  cmp_val,
    output logic              int_st,
    output logic              intr
);

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic              en_q;
    logic              inc;
    logic              match;
    logic [CNT_W-1:0]  cnt_d;
    logic [CNT_W-1:0]  cmp_d;
    logic              int_d;

    // Halt FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Halt FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:    if (halt_req && timer_en)   state_d = HALTED;
            HALTED: if (!halt_req || !timer_en) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // Halt FSM: outputs. halt_req blocks counting combinationally so the
    // counter freezes in the same cycle the request rises, before the ack.
    always_comb begin
        halt_ack = (state_q == HALTED);
        inc      = timer_en && count_en && !halt_req && (state_q == RUN);
    end

    // Counter next value: software write > disable edge > increment > hold.
    always_comb begin
        cnt_d = cnt_val;
        if (cnt_wr_lo || cnt_wr_hi) begin
            if (cnt_wr_lo) cnt_d[DATA_W-1:0]     = wdata;
            if (cnt_wr_hi) cnt_d[CNT_W-1:DATA_W] = wdata;
        end else if (en_q && !timer_en) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_val + CNT_W'(1);
        end
    end

    always_comb begin
        cmp_d = cmp_val;
        if (cmp_wr_lo) cmp_d[DATA_W-1:0]     = wdata;
        if (cmp_wr_hi) cmp_d[CNT_W-1:DATA_W] = wdata;
    end

    // Match on registered values; a set in the same cycle as a clear wins.
    always_comb begin
        match = timer_en && (cnt_val == cmp_val);
        int_d = int_st;
        if (match) begin
            int_d = 1'b1;
        end else if (int_clr) begin
            int_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_val <= '0;
            cmp_val <= CMP_RST;
            int_st  <= 1'b0;
            en_q    <= 1'b0;
        end else begin
            cnt_val <= cnt_d;
            cmp_val <= cmp_d;
            int_st  <= int_d;
            en_q    <= timer_en;
        end
    end

    assign intr = int_st && int_en;

endmodule

// File: tb/tb_timer_counter.sv
// Self-checking bench for timer_counter: directed scenarios with fixed
// expected values, then randomized traffic against a behavioural model.
module tb_timer_counter;

    logic        clk = 1'b0;
    logic        rst;
    logic        timer_en, count_en, halt_req, halt_ack;
    logic [31:0] wdata;
    logic        cnt_wr_lo, cnt_wr_hi, cmp_wr_lo, cmp_wr_hi;
    logic        int_en, int_clr;
    logic [63:0] cnt_val, cmp_val;
    logic        int_st, intr;

    int unsigned n_chk  = 0;
    int unsigned n_fail = 0;

    // Reference model state
    logic [63:0] m_cnt, m_cmp;
    logic        m_int, m_halt, m_prev_en;

    timer_counter #(.DATA_W(32), .CNT_W(64), .CMP_RST(64'hFFFF_FFFF_FFFF_FFFF)) dut (
        .clk      (clk),
        .rst      (rst),
        .timer_en (timer_en),
        .count_en (count_en),
        .halt_req (halt_req),
        .halt_ack (halt_ack),
        .wdata    (wdata),
        .cnt_wr_lo(cnt_wr_lo),
        .cnt_wr_hi(cnt_wr_hi),
        .cmp_wr_lo(cmp_wr_lo),
        .cmp_wr_hi(cmp_wr_hi),
        .int_en   (int_en),
        .int_clr  (int_clr),
        .cnt_val  (cnt_val),
        .cmp_val  (cmp_val),
        .int_st   (int_st),
        .intr     (intr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt     = 64'd0;
        m_cmp     = 64'hFFFF_FFFF_FFFF_FFFF;
        m_int     = 1'b0;
        m_halt    = 1'b0;
        m_prev_en = 1'b0;
    endtask

    // One clock of the model, computed from the inputs currently applied.
    // The halt handshake reduces to: halted next cycle iff the request is
    // present while the timer is enabled.
    task automatic model_step();
        logic        adv, hit;
        logic [63:0] n_cnt;
        adv = timer_en && count_en && !halt_req && !m_halt;
        hit = timer_en && (m_cnt == m_cmp);
        n_cnt = m_cnt;
        if (cnt_wr_lo || cnt_wr_hi) begin
            if (cnt_wr_lo) n_cnt = {n_cnt[63:32], wdata};
            if (cnt_wr_hi) n_cnt = {wdata, n_cnt[31:0]};
        end else if (m_prev_en && !timer_en) begin
            n_cnt = 64'd0;
        end else if (adv) begin
            n_cnt = m_cnt + 64'd1;
        end
        if (cmp_wr_lo) m_cmp = {m_cmp[63:32], wdata};
        if (cmp_wr_hi) m_cmp = {wdata, m_cmp[31:0]};
        m_int     = hit ? 1'b1 : (int_clr ? 1'b0 : m_int);
        m_halt    = halt_req && timer_en;
        m_prev_en = timer_en;
        m_cnt     = n_cnt;
    endtask

    task automatic check_model();
        chk("cnt_val",  cnt_val,  m_cnt);
        chk("cmp_val",  cmp_val,  m_cmp);
        chk("int_st",   64'(int_st),   64'(m_int));
        chk("halt_ack", 64'(halt_ack), 64'(m_halt));
        chk("intr",     64'(intr),     64'(m_int && int_en));
    endtask

    task automatic idle_inputs();
        cnt_wr_lo = 1'b0; cnt_wr_hi = 1'b0;
        cmp_wr_lo = 1'b0; cmp_wr_hi = 1'b0;
        int_clr   = 1'b0;
    endtask

    // Inputs are set by the caller one step after an edge; this advances one
    // clock and samples 1 time unit after the edge.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_model();
        idle_inputs();
    endtask

    task automatic write_cnt(input logic [63:0] v);
        wdata = v[31:0]; cnt_wr_lo = 1'b1; tick();
        wdata = v[63:32]; cnt_wr_hi = 1'b1; tick();
    endtask

    task automatic write_cmp(input logic [63:0] v);
        wdata = v[31:0]; cmp_wr_lo = 1'b1;
        tick();
        wdata = v[63:32]; cmp_wr_hi = 1'b1;
        tick();
    endtask

    task automatic check_reset_now(input string tag);
        chk({tag, "_cnt"},  cnt_val, 64'd0);
        chk({tag, "_cmp"},  cmp_val, 64'hFFFF_FFFF_FFFF_FFFF);
        chk({tag, "_int"},  64'(int_st),   64'd0);
        chk({tag, "_ack"},  64'(halt_ack), 64'd0);
        chk({tag, "_intr"}, 64'(intr),     64'd0);
    endtask

    initial begin
        rst = 1'b1;
        timer_en = 1'b0; count_en = 1'b0; halt_req = 1'b0; int_en = 1'b0;
        wdata = '0;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_now("rst_init");
        rst = 1'b0;

        // Count through the 64-bit wrap
        timer_en = 1'b1; count_en = 1'b1;
        wdata = 32'hFFFF_FFFE; cnt_wr_lo = 1'b1; tick();
        wdata = 32'hFFFF_FFFF; cnt_wr_hi = 1'b1; tick();
        chk("wrap_wr", cnt_val, 64'hFFFF_FFFF_FFFF_FFFE);
        tick(); chk("wrap_max", cnt_val, 64'hFFFF_FFFF_FFFF_FFFF);
        tick(); chk("wrap_zero", cnt_val, 64'd0);
        tick(); chk("wrap_one", cnt_val, 64'd1);
        wdata = 32'hFFFF_FFFF; cnt_wr_lo = 1'b1; tick();
        chk("carry_wr", cnt_val, 64'h0000_0000_FFFF_FFFF);
        tick(); chk("carry_inc", cnt_val, 64'h0000_0001_0000_0000);

        // Gated counting, then disable edge
        count_en = 1'b0;
        int_clr = 1'b1; tick();
        cnt_wr_lo = 1'b1; cnt_wr_hi = 1'b1; wdata = '0; tick();
        for (int i = 0; i < 40; i++) begin
            count_en = (i % 4 == 0);
            tick();
        end
        chk("gated_10", cnt_val, 64'd10);
        timer_en = 1'b0; count_en = 1'b0; tick();
        chk("dis_zero", cnt_val, 64'd0);
        for (int i = 0; i < 8; i++) begin
            count_en = (i % 2 == 0);
            tick();
        end
        chk("dis_hold", cnt_val, 64'd0);

        // Compare and interrupt
        timer_en = 1'b1; count_en = 1'b0; int_en = 1'b1;
        write_cmp(64'd5);
        int_clr = 1'b1; tick();
        count_en = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 5) chk("cmp_pre", 64'(int_st), 64'd0);
            if (k == 6) begin
                chk("cmp_set", 64'(int_st), 64'd1);
                chk("cmp_intr", 64'(intr), 64'd1);
            end
        end
        chk("cmp_at8", cnt_val, 64'd8);
        int_clr = 1'b1; tick();
        chk("clr_int", 64'(int_st), 64'd0);
        count_en = 1'b0;
        write_cmp(64'd9);
        tick();
        chk("stall_set", 64'(int_st), 64'd1);
        int_clr = 1'b1; tick();
        chk("stall_reset", 64'(int_st), 64'd1);
        int_en = 1'b0; tick();
        chk("mask_intr", 64'(intr), 64'd0);
        chk("mask_keep", 64'(int_st), 64'd1);

        // Halt handshake
        count_en = 1'b1;
        write_cnt(64'd3);
        count_en = 1'b0; cnt_wr_lo = 1'b1; wdata = 32'd3; tick();
        count_en = 1'b1; halt_req = 1'b1; tick();
        chk("halt_frz", cnt_val, 64'd3);
        chk("halt_ack1", 64'(halt_ack), 64'd1);
        tick(); chk("halt_hold", cnt_val, 64'd3);
        halt_req = 1'b0; tick();
        chk("halt_ack0", 64'(halt_ack), 64'd0);
        chk("halt_rel", cnt_val, 64'd3);
        tick(); chk("halt_resume", cnt_val, 64'd4);

        // Simultaneous events
        count_en = 1'b1; wdata = 32'h100; cnt_wr_lo = 1'b1; tick();
        chk("wr_beats_inc", cnt_val, 64'h100);
        count_en = 1'b0;
        write_cmp(64'h200);
        int_clr = 1'b1; tick();
        chk("pre_clr", 64'(int_st), 64'd0);
        wdata = 32'h200; cnt_wr_lo = 1'b1; tick();
        int_clr = 1'b1; tick();
        chk("set_beats_clr", 64'(int_st), 64'd1);
        timer_en = 1'b0; wdata = 32'h1234; cnt_wr_lo = 1'b1; tick();
        chk("wr_beats_dis", cnt_val, 64'h1234);

        // Reset while counting and halted
        timer_en = 1'b1; count_en = 1'b1; halt_req = 1'b1; int_en = 1'b1;
        tick(); tick();
        #2 rst = 1'b1;
        #1 check_reset_now("rst_mid");
        model_reset();
        halt_req = 1'b0; count_en = 1'b0; timer_en = 1'b0; int_en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            timer_en = ($urandom_range(0, 19) != 0);
            count_en = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 9) == 0) halt_req = ~halt_req;
            int_en  = ($urandom_range(0, 3) != 0);
            int_clr = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 3))
                0: wdata = 32'hFFFF_FFFF;
                1: wdata = $urandom();
                default: wdata = $urandom_range(0, 40);
            endcase
            cnt_wr_lo = ($urandom_range(0, 29) == 0);
            cnt_wr_hi = ($urandom_range(0, 29) == 0);
            cmp_wr_lo = ($urandom_range(0, 24) == 0);
            cmp_wr_hi = ($urandom_range(0, 24) == 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
